// File: rtl/wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter
//  This block shares the single register-file write port between the in-order
//  pipeline writeback stage and a multi-cycle result source.
//
//  Arbitration:
//   - Pipeline writes win by default.
//   - Multi-cycle results always queue in a small FIFO and drain into idle
//     port slots.
//   - If the FIFO head goes ungranted for STARVE_LIMIT edges, a one-cycle
//     FORCE state stalls the pipeline and drains the head.
//
//  Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   wb_valid/addr/data    pipeline writeback request
//   mc_valid/addr/data    multi-cycle result, held by the source until accepted
//   mc_ready              FIFO has room
//   stall_pipe            high exactly while in the FORCE state
//   rf_we/waddr/wdata     registered register-file write port
//   pending_mask          one bit per register targeted by a queued entry
//   fifo_count            occupied FIFO entries
// ----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int unsigned DW           = 32,
   parameter int unsigned AW           = 4,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wb_valid,
   input  logic [AW-1:0]           wb_addr,
   input  logic [DW-1:0]           wb_data,
   input  logic                    mc_valid,
   output logic                    mc_ready,
   input  logic [AW-1:0]           mc_addr,
   input  logic [DW-1:0]           mc_data,
   output logic                    stall_pipe,
   output logic                    rf_we,
   output logic [AW-1:0]           rf_waddr,
   output logic [DW-1:0]           rf_wdata,
   output logic [(1<<AW)-1:0]      pending_mask,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned WW   = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
   logic            stall_q, stall_d;

   logic [AW-1:0]   fifo_addr_q [DEPTH];
   logic [DW-1:0]   fifo_data_q [DEPTH];

   logic            push;
   logic            pop;
   logic            head_valid;
   logic            full;
   logic [PW-1:0]   slot_off;

   // Control and write-port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_NORMAL;
         wait_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         stall_q    <= stall_d;
      end
   end

   // FIFO storage; validity is carried entirely by the pointers and count
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= mc_addr;
         fifo_data_q[wr_ptr_q] <= mc_data;
      end
   end

   // Grant, FIFO bookkeeping and starvation FSM
   always_comb begin
      state_d    = state_q;
      wait_d     = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      stall_d    = 1'b0;
      pop        = 1'b0;

      full       = (count_q == CW'(DEPTH));
      head_valid = (count_q != '0);
      push       = mc_valid && !full;

      // In FORCE the stalled pipeline re-presents its request, so wb_valid is ignored
      if (state_q == ST_NORMAL && wb_valid) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = wb_addr;
         rf_wdata_d = wb_data;
      end else if (head_valid) begin
         pop        = 1'b1;
         rf_we_d    = 1'b1;
         rf_waddr_d = fifo_addr_q[rd_ptr_q];
         rf_wdata_d = fifo_data_q[rd_ptr_q];
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      case (state_q)
         ST_NORMAL: begin
            if (head_valid && !pop) begin
               if (wait_q == WW'(STARVE_LIMIT - 1)) begin
                  state_d = ST_FORCE;
                  stall_d = 1'b1;
               end else begin
                  wait_d = wait_q + WW'(1);
               end
            end
         end
         ST_FORCE: begin
            state_d = ST_NORMAL;
         end
         default: begin
            state_d = ST_NORMAL;
         end
      endcase
   end

   // Decode of the destinations held by live FIFO slots
   always_comb begin
      pending_mask = '0;
      slot_off     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot_off = PW'(i) - rd_ptr_q;
         if (CW'(slot_off) < count_q) begin
            pending_mask[fifo_addr_q[i]] = 1'b1;
         end
      end
   end

   assign mc_ready   = (count_q != CW'(DEPTH));
   assign fifo_count = count_q;
   assign stall_pipe = stall_q;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;

endmodule
